// File: rtl/pipe_skid_reg.sv
// Two-entry valid/ready pipeline register for MIPS32 inter-stage boundaries.
// Upstream side accepts a word into the main register (or into the skid
// register when downstream stalls). Downstream side always presents the main
// register. in_ready_o depends only on local state and flush_i, never on
// out_ready_i, which breaks the ready timing chain between stages.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   flush_i      synchronous squash of all held words
//   in_valid_i   upstream word present
//   in_data_i    upstream word
//   in_ready_o   block can accept a word this cycle
//   out_valid_o  downstream word present
//   out_data_o   downstream word
//   out_ready_i  downstream accepts the word this cycle
//   count_o      occupancy, 0..2
module pipe_skid_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_ready_i,
  output logic [1:0]       count_o
);

  // Encoding doubles as {skid_v, main_v}.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b01,
    StFull  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;

  logic main_v;
  logic skid_v;
  logic in_acc;
  logic out_acc;

  assign main_v  = state_q[0];
  assign skid_v  = state_q[1];

  assign in_ready_o  = ~skid_v & ~flush_i;
  assign out_valid_o = main_v;
  assign out_data_o  = main_q;
  assign count_o     = {1'b0, main_v} + {1'b0, skid_v};

  assign in_acc  = in_valid_i & in_ready_o;
  assign out_acc = main_v & out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      // Data registers keep stale contents; out_valid_o=0 masks them.
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_acc) begin
            state_d = StOne;
            main_d  = in_data_i;
          end
        end
        StOne: begin
          if (in_acc && out_acc) begin
            main_d = in_data_i;
          end else if (in_acc) begin
            // Downstream stalled: park the new word behind main.
            state_d = StFull;
            skid_d  = in_data_i;
          end else if (out_acc) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          // in_ready_o is low here, so only draining can happen.
          if (out_acc) begin
            state_d = StOne;
            main_d  = skid_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg. The reference model is a bounded FIFO (capacity 2)
// held as a queue: the stimulus side pushes every word it expects to be
// accepted, the monitor pops on each downstream transfer and checks order,
// data, occupancy and ready/valid against the queue.
module tb_pipe_skid_reg;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst_ni;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic [1:0]   count;

  pipe_skid_reg #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_ready_i (out_ready),
    .count_o     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int           pend;     // 1 if the word driven this cycle was pushed but not yet clocked in
  bit           mon_en;
  int           tests;
  int           fails;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: sample mid-cycle, with the inputs for the coming edge stable.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_ni) begin
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_out_data", out_data, W'(0));
        check("rst_count", W'(count), W'(0));
        check("rst_in_ready", W'(in_ready), W'(!flush));
      end else begin
        int occ;
        occ = exp_q.size() - pend;
        check("count", W'(count), W'(occ));
        check("out_valid", W'(out_valid), W'(occ > 0));
        check("in_ready", W'(in_ready), W'((occ < 2) && !flush));
        if (occ > 0) begin
          check("out_data", out_data, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
        // A squash drops everything the consumer has not taken.
        if (flush) exp_q.delete();
      end
    end
  end

  // Drive one cycle of stimulus; called at posedge+1.
  task automatic cycle(input bit v, input logic [W-1:0] d, input bit ordy, input bit fl);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    pend      = 0;
    if (v && !fl && exp_q.size() < 2) begin
      exp_q.push_back(d);
      pend = 1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    pend      = 0;
    mon_en    = 1'b0;
    rst_ni    = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset with a word on the input: nothing may be captured.
    #25;
    rst_ni   = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'hDEAD;
    #1;
    mon_en = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    exp_q.delete();
    rst_ni = 1'b1;

    // Streaming at full rate.
    for (int i = 0; i < 12; i++) cycle(1'b1, W'(i), 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Stall into the skid register, then drain.
    cycle(1'b1, W'(5), 1'b1, 1'b0);
    cycle(1'b1, W'(6), 1'b0, 1'b0);
    cycle(1'b1, W'(77), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    repeat (4) cycle(1'b0, '0, 1'b1, 1'b0);

    // Simultaneous accept and drain while holding one word.
    cycle(1'b1, W'(7), 1'b0, 1'b0);
    cycle(1'b1, W'(8), 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Flush while full; 9 must never be seen.
    cycle(1'b1, W'(3), 1'b0, 1'b0);
    cycle(1'b1, W'(4), 1'b0, 1'b0);
    cycle(1'b1, W'(9), 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    // Flush while full with a completing downstream transfer.
    cycle(1'b1, W'(10), 1'b0, 1'b0);
    cycle(1'b1, W'(11), 1'b0, 1'b0);
    cycle(1'b1, W'(12), 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset mid-stall, between clock edges.
    cycle(1'b1, W'(1), 1'b0, 1'b0);
    cycle(1'b1, W'(2), 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_ni = 1'b0;
    exp_q.delete();
    pend = 0;
    #1;
    check("async_rst_out_valid", W'(out_valid), W'(0));
    check("async_rst_count", W'(count), W'(0));
    @(posedge clk);
    #1;
    rst_ni = 1'b1;

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), W'($urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 15) == 0));
    end
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Two-entry valid/ready pipeline register for inter-stage boundaries of the MIPS32 datapath.
- It is the consuming end of a stage handshake: it accepts a word from the upstream stage and presents it downstream.
- It holds a second word when downstream stalls, so upstream ready never depends combinationally on downstream ready.
- Supports a synchronous flush for branch/exception squash.

Parameters:
- WIDTH, 32, data word width in bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous reset, active-low (asserted when 0).
- flush  input  1  synchronous squash of all held words.
- in_valid  input  1  upstream word present.
- in_data  input  WIDTH  upstream word.
- in_ready  output  1  block can accept a word this cycle.
- out_valid  output  1  downstream word present.
- out_data  output  WIDTH  downstream word.
- out_ready  input  1  downstream accepts the word this cycle.
- count  output  2  occupancy, 0..2.

Behaviour:
- Handshakes:
  - Upstream transfer ("in_acc") occurs when in_valid && in_ready at a rising edge.
  - Downstream transfer ("out_acc") occurs when out_valid && out_ready at a rising edge.
- Storage: main register (main_q, main_v) and skid register (skid_q, skid_v).
- States: EMPTY (main_v=0, skid_v=0), ONE (main_v=1, skid_v=0), FULL (main_v=1, skid_v=1). No other encoding is reachable.
- Outputs:
  - out_valid = main_v.
  - out_data = main_q.
  - count = main_v + skid_v.
  - in_ready = !skid_v && !flush. This is the only combinational input-to-output path.
- Reset (reset=0, asynchronous): state EMPTY; main_q, skid_q = 0. Resulting outputs: out_valid=0, out_data=0, count=0, in_ready=1 (given flush=0). Release is sampled on the next clk edge.
- Transitions when flush=0:
  - EMPTY, in_acc -> ONE; main_q <= in_data.
  - EMPTY, no in_acc -> EMPTY.
  - ONE, in_acc && out_acc -> ONE; main_q <= in_data.
  - ONE, in_acc && !out_acc -> FULL; skid_q <= in_data; main_q unchanged.
  - ONE, !in_acc && out_acc -> EMPTY.
  - ONE, neither -> ONE, all held.
  - FULL: in_ready=0. On out_acc -> ONE, main_q <= skid_q. Otherwise hold.
- Flush=1 at an edge:
  - Next state EMPTY regardless of in_valid/out_ready.
  - in_ready is 0 during flush, so no upstream word is accepted.
  - A downstream transfer with out_ready=1 in that cycle still completes; the consumer has seen it.
  - Data registers may keep stale contents; out_valid=0 makes them don't-care.
- Latency and throughput:
  - A word accepted at edge N appears on out_valid/out_data after edge N (1-cycle latency).
  - Sustained throughput is 1 word/cycle with out_ready held high.
- Ordering: words exit in acceptance order. None duplicated, none dropped except by flush or reset.
- Stability: while out_valid && !out_ready, out_data and out_valid hold constant.
- Reset mid-operation: all held words are lost immediately; outputs take their reset values.
- Width: all data paths are WIDTH bits, with no truncation or extension.

Test Plan:
- Reset: drive reset=0 at t=25ns with in_valid=1, in_data=32'hDEAD -> out_valid=0, out_data=0, count=0, in_ready=1 until release.
- Streaming: release reset; feed 0,1,2,...,11 one per cycle with out_ready=1 -> out_data shows 0..11 on consecutive cycles, one cycle after each acceptance, and count stays 1.
- Stall/skid: with main holding 5, drop out_ready and present 6 -> count=2, in_ready=0, out_data holds 5. Raise out_ready -> out 5 then 6, count 2->1->0.
- Simultaneous accept/drain in ONE: main=7, in_valid=1 with data 8, out_ready=1 -> next cycle out_data=8, count=1.
- Flush in FULL: main=3, skid=4, flush=1 with in_valid=1 and data 9 -> next cycle out_valid=0, count=0, and 9 never appears downstream.
- Asynchronous reset mid-stall: FULL state, pulse reset=0 between edges -> out_valid drops to 0 and count drops to 0 immediately, without waiting for clk.
